lsu_data_memory: RTL
====================

LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter READ_LAT, default 1, meaning load latency in cycles; legal range 1..4.
REQ-003 SHALL have parameter INIT_PATTERN, default 1; when 1, word i initialises to i at time zero; when 0, every word initialises to 0.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit, request present.
REQ-007 SHALL have port req_ready, output, 1 bit, block can accept a request this cycle.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-010 SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-011 SHALL have port addr, input, 32 bits, byte address.
REQ-012 SHALL have port write_data, input, 32 bits, store data taken from the low bits for byte and half stores.
REQ-013 SHALL have port rsp_valid, output, 1 bit, one-cycle response pulse.
REQ-014 SHALL have port read_data, output, 32 bits, extended load result.
REQ-015 SHALL have port err, output, 1 bit, request rejected.
REQ-016 SHALL have port err_code, output, 2 bits: 00 = none, 01 = misaligned, 10 = out of range, 11 = reserved size.

Function
REQ-017 SHALL accept a request at a rising edge when req_valid = 1 and req_ready = 1, latching all request fields.
REQ-018 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL set the latency L to READ_LAT for loads, to 1 for stores and to 1 for errored requests.
REQ-020 SHALL, on accept, go to RESP when L = 1; otherwise it SHALL go to WAIT with a counter loaded to L-1, decrement each cycle, and go to RESP when the counter reaches 0.
REQ-021 SHALL hold rsp_valid = 1 for exactly the one RESP cycle, then return to IDLE; rsp_valid rises L edges after the accept edge.
REQ-022 SHALL ignore req_valid outside IDLE, with no side effects.
REQ-023 SHALL compute the word index as addr[31:2] and the byte lane as addr[1:0], with little-endian lanes (lane 0 = bits 7:0).
REQ-024 SHALL flag misaligned when a half access has addr[0] = 1 or a word access has addr[1:0] != 0.
REQ-025 SHALL flag out of range when the word index >= DEPTH.
REQ-026 SHALL apply error priority reserved size > misaligned > out of range.
REQ-027 SHALL, on an errored request, leave memory unmodified and drive err = 1, the matching err_code and read_data = 0 during RESP.
REQ-028 SHALL commit a store at the accept edge, writing only the addressed byte lanes (byte: 1 lane; half: lanes 1:0 or 3:2; word: all 4).
REQ-029 SHALL sample a load's memory word at the accept edge, so that a store accepted earlier is visible to it.
REQ-030 SHALL, for loads, right-align the selected byte or half and extend it per req_unsigned; word loads are passed unchanged.
REQ-031 SHALL drive read_data = 0 in a store response.
REQ-032 SHALL drive read_data, err and err_code to 0 whenever rsp_valid = 0.

Reset
REQ-033 SHALL, while rst = 1 at an edge, force the FSM to IDLE, clear the counter and drive rsp_valid = 0, read_data = 0, err = 0 and err_code = 00.
REQ-034 SHALL drop any request in flight when rst is asserted mid-operation, producing no response; a store already committed SHALL remain.
REQ-035 SHALL NOT re-initialise memory contents on rst; INIT_PATTERN applies at time zero only.
REQ-036 SHALL drive req_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-037 SHALL test: READ_LAT = 3, LW at addr 0x14 -> rsp_valid rises 3 edges after accept with read_data = 0x00000005, err = 0.
REQ-038 SHALL test: SB of write_data 0x000000AB at addr 0x21, then LW at 0x20 -> read_data = 0x0000AB08.
REQ-039 SHALL test: SB of 0x80 at addr 0x30, then LB at 0x30 -> 0xFFFFFF80 and LBU at 0x30 -> 0x00000080.
REQ-040 SHALL test: LW at 0x22 -> err = 1, err_code = 01, read_data = 0; a following LW at 0x20 returns the unchanged word.
REQ-041 SHALL test: DEPTH = 256, SW at 0x400 -> err_code = 10, and no memory word changes.
REQ-042 SHALL test: READ_LAT = 4, rst pulsed 2 cycles after a load is accepted -> no rsp_valid, and req_ready = 1 in the cycle after rst deasserts.

Source files
------------

// File: rtl/lsu_data_memory.sv
// Word-organised data memory behind a load/store request port.
// Fixed-latency responses, byte-lane stores, sign/zero-extended loads.
module lsu_data_memory #(
    parameter int DEPTH        = 256,
    parameter int READ_LAT     = 1,
    parameter bit INIT_PATTERN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        rsp_valid,
    output logic [31:0] read_data,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [1:0]  LD_WAIT = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;
    logic [1:0] cnt, cnt_next;

    logic        accept;
    logic [1:0]  lane;
    logic [AW-1:0] widx;
    logic        size_bad, misaligned, out_of_range;
    logic [1:0]  err_c;
    logic        req_err;
    logic [1:0]  lat_m1;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wlanes;
    logic [31:0] rd_word;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic [31:0] res_data;
    logic        res_err;
    logic [1:0]  res_code;

    logic [31:0] rd_arr [DEPTH];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign lane      = addr[1:0];
    assign widx      = addr[AW+1:2];

    assign size_bad     = (req_size == 2'b11);
    assign misaligned   = ((req_size == 2'b01) && addr[0]) ||
                          ((req_size == 2'b10) && (addr[1:0] != 2'b00));
    assign out_of_range = ({2'b00, addr[31:2]} >= DEPTH_W);

    always_comb begin
        err_c = 2'b00;
        priority case (1'b1)
            size_bad:     err_c = 2'b11;
            misaligned:   err_c = 2'b01;
            out_of_range: err_c = 2'b10;
            default:      err_c = 2'b00;
        endcase
    end

    assign req_err = (err_c != 2'b00);
    assign lat_m1  = (req_write || req_err) ? 2'd0 : LD_WAIT;
    assign we      = accept && req_write && !req_err;

    always_comb begin
        be     = 4'b0000;
        wlanes = write_data;
        unique case (req_size)
            2'b00: begin
                be     = 4'b0001 << lane;
                wlanes = {4{write_data[7:0]}};
            end
            2'b01: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{write_data[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // One register per word so each can carry its own power-up value.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [31:0] mem_word = INIT_PATTERN ? 32'(i) : 32'd0;

        always_ff @(posedge clk) begin
            if (we && (widx == AW'(i))) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_word[8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end

        assign rd_arr[i] = mem_word;
    end

    assign rd_word = out_of_range ? 32'd0 : rd_arr[widx];
    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = 32'd0;
        unique case (req_size)
            2'b00:   ld_data = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~req_unsigned & ld_half[15]}}, ld_half};
            2'b10:   ld_data = rd_word;
            default: ld_data = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next   = lat_m1;
                    state_next = (lat_m1 == 2'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 2'd1) begin
                    cnt_next   = 2'd0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Load data is captured at accept so it reflects every earlier store.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data <= 32'd0;
            res_err  <= 1'b0;
            res_code <= 2'b00;
        end else if (accept) begin
            res_data <= (req_err || req_write) ? 32'd0 : ld_data;
            res_err  <= req_err;
            res_code <= err_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state != RESP)) begin
            rsp_valid <= 1'b0;
            read_data <= 32'd0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            rsp_valid <= 1'b1;
            read_data <= res_data;
            err       <= res_err;
            err_code  <= res_code;
        end
    end

endmodule
